// File: rtl/fpga_cfg_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// Holds the loader state encoding and the default chain/word geometry.
package fpga_cfg_pkg;

    localparam int CHAIN_LEN_DEF = 27;
    localparam int WORD_W_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_WORD,
        ST_SHIFT,
        ST_DONE
    } ld_state_e;

endpackage

// File: rtl/ccff_word_serializer.sv
// Per-word shift register: latches a host word and presents it LSB first.
// last_bit flags the cycle that carries the final bit of the word.
module ccff_word_serializer
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              head_bit,
    output logic              last_bit
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = data;
            idx_d   = '0;
        end else if (shift) begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign head_bit = shreg_q[0];
    assign last_bit = (idx_q == IDX_LAST);

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams host words into a configuration flip-flop chain and packs the
// bits falling out of the tail back into readback words.
module ccff_chain_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int WORD_W    = WORD_W_DEF
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int RW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [RW-1:0] RB_LAST  = RW'(WORD_W - 1);

    ld_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     rb_idx_q, rb_idx_d;
    logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              err_q, err_d;

    logic              shifting;
    logic              ser_load;
    logic              ser_head;
    logic              ser_last;
    logic              chain_end;
    logic [WORD_W-1:0] rb_next;

    assign shifting  = (state_q == ST_SHIFT);
    assign ser_load  = (state_q == ST_WAIT_WORD) && s_valid && !abort;
    assign chain_end = (cnt_q == CNT_LAST);
    assign rb_next   = rb_acc_q | (WORD_W'(ccff_tail) << rb_idx_q);

    ccff_word_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .clk     (prog_clk),
        .rst     (pReset),
        .load    (ser_load),
        .shift   (shifting),
        .data    (s_data),
        .head_bit(ser_head),
        .last_bit(ser_last)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rb_idx_d   = rb_idx_q;
        rb_acc_d   = rb_acc_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        err_d      = err_q;

        // Tail capture runs on every shift; a full or final word is published.
        if (shifting) begin
            cnt_d    = cnt_q + 1'b1;
            rb_acc_d = rb_next;
            rb_idx_d = rb_idx_q + 1'b1;
            if (rb_idx_q == RB_LAST || chain_end) begin
                rb_valid_d = 1'b1;
                rb_data_d  = rb_next;
                rb_acc_d   = '0;
                rb_idx_d   = '0;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_WAIT_WORD;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    rb_idx_d = '0;
                    rb_acc_d = '0;
                end
            end
            ST_WAIT_WORD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (s_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    rb_valid_d = 1'b0;
                    rb_data_d  = rb_data_q;
                end else if (ser_last || chain_end) begin
                    state_d = chain_end ? ST_DONE : ST_WAIT_WORD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rb_idx_q   <= '0;
            rb_acc_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rb_idx_q   <= rb_idx_d;
            rb_acc_q   <= rb_acc_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            err_q      <= err_d;
        end
    end

    assign s_ready       = (state_q == ST_WAIT_WORD);
    assign config_enable = shifting;
    assign ccff_head     = shifting & ser_head;
    assign busy          = (state_q == ST_WAIT_WORD) || shifting;
    assign done          = (state_q == ST_DONE);
    assign rb_valid      = rb_valid_q;
    assign rb_data       = rb_data_q;
    assign err           = err_q;

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 27: configuration-chain length in bits (9 routing muxes x 3 SRAM bits).
REQ-002 SHALL have parameter WORD_W, default 32: width of the host data and readback words.
REQ-003 SHALL have port prog_clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port pReset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: starts a load when sampled high in IDLE.
REQ-006 SHALL have port abort, input, 1: cancels a load in progress.
REQ-007 SHALL have port s_valid, input, 1: host word valid.
REQ-008 SHALL have port s_ready, output, 1: loader accepts a word.
REQ-009 SHALL have port s_data, input, WORD_W: host word, LSB shifted first.
REQ-010 SHALL have port ccff_head, output, 1: serial bit into the chain.
REQ-011 SHALL have port config_enable, output, 1: chain shift enable.
REQ-012 SHALL have port ccff_tail, input, 1: serial bit out of the chain.
REQ-013 SHALL have port rb_valid, output, 1: one-cycle readback-word strobe.
REQ-014 SHALL have port rb_data, output, WORD_W: old chain contents, LSB first.
REQ-015 SHALL have port busy, output, 1: high in WAIT_WORD and SHIFT.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-017 SHALL have port err, output, 1: sticky abort flag.

Function
REQ-018 SHALL implement the states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-019 IDLE with start=1 SHALL go to WAIT_WORD next cycle, clear err and clear the bit counters; start in any other state SHALL be ignored.
REQ-020 s_ready SHALL be high only in WAIT_WORD; an accepted word (s_valid & s_ready) SHALL be latched and the state SHALL go to SHIFT next cycle.
REQ-021 In SHIFT, config_enable SHALL be 1 and ccff_head SHALL carry latched bit k on the k-th SHIFT cycle of that word, k = 0 upward.
REQ-022 Outside SHIFT, config_enable SHALL be 0 and ccff_head 0, so the chain holds while waiting for data.
REQ-023 Exactly CHAIN_LEN shift cycles SHALL occur per load, using ceil(CHAIN_LEN/WORD_W) words; the unused upper bits of the final word SHALL be discarded.
REQ-024 After the last bit of a word, the state SHALL go to DONE if the total count has reached CHAIN_LEN, else to WAIT_WORD.
REQ-025 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-026 ccff_tail SHALL be captured in every cycle with config_enable=1 into rb_data at the next free bit position, LSB first.
REQ-027 rb_valid SHALL pulse for one cycle, the cycle after WORD_W bits have been captured or after the final chain bit; unfilled rb_data bits SHALL be 0.
REQ-028 rb_data SHALL hold its value until the next rb_valid.
REQ-029 abort in WAIT_WORD or SHIFT SHALL force IDLE next cycle, drop config_enable in that same next cycle, set err and suppress done and rb_valid.
REQ-030 abort and start in the same cycle in IDLE: start SHALL win.
REQ-031 The counters SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap within one load.

Reset
REQ-032 pReset SHALL put the block in IDLE with s_ready, config_enable, ccff_head, rb_valid, rb_data, busy, done and err all 0.
REQ-033 pReset mid-load SHALL behave like abort, except that err stays 0.

Structure
REQ-034 The state enumeration and the default CHAIN_LEN/WORD_W values SHALL live in the shared package fpga_cfg_pkg.
REQ-035 The per-word shift register and bit-index logic SHALL be one sub-module, ccff_word_serializer; the FSM and readback packing SHALL stay in the top module.

Verification
REQ-036 The bench SHALL model the chain as a 27-bit shift register gated by config_enable, with ccff_tail equal to its last bit.
REQ-037 After reset, start, then word 0x05A5A5A5 with s_valid held -> exactly 27 config_enable cycles, head bits 1,0,1,0,0,1,0,1,..., done 28 cycles after acceptance, chain model equals 0x5A5A5A5, rb_data = 0 with one rb_valid.
REQ-038 A second load of 0x00000000 -> rb_data = 0x05A5A5A5 (27 LSBs), chain model all zero.
REQ-039 With WORD_W=8, s_valid withheld for 5 cycles between words -> config_enable low during the gaps, 4 words accepted, total of 27 shift cycles, chain content correct.
REQ-040 abort on the 10th SHIFT cycle -> config_enable low next cycle, err=1, no done; a following start clears err.
REQ-041 pReset asserted on the 10th SHIFT cycle -> all outputs 0 next cycle and err=0; start pulsed while busy -> no effect on the counters.
